// File: rtl/soc_pkg.sv
// Shared SoC constants and types: SRAM address window and the OBI response tag.
package soc_pkg;

   localparam logic [31:0] SRAM_BASE = 32'h8000_0000;
   localparam logic [31:0] SRAM_END  = 32'h8000_C000;

   // id selects the master the response belongs to; err marks a request that never reached SRAM
   typedef struct packed {
      logic id;
      logic err;
   } rsp_tag_t;

   function automatic logic in_window(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] lim);
      return (addr >= base) && (addr < lim);
   endfunction

endpackage

// File: rtl/obi_rsp_fifo.sv
// Small synchronous FIFO of response tags, one entry per granted request still owed a response.
module obi_rsp_fifo
   import soc_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  logic     push_i,
   input  rsp_tag_t data_i,
   input  logic     pop_i,
   output rsp_tag_t head_o,
   output logic     full_o,
   output logic     empty_o
);

   localparam logic [1:0] LAST = 2'(DEPTH - 1);
   localparam logic [2:0] FULL_CNT = 3'(DEPTH);

   // Storage sized for the largest legal depth so the 2-bit pointers index it exactly
   rsp_tag_t   mem [4];
   logic [1:0] wr_ptr, rd_ptr;
   logic [2:0] count;
   logic       do_push, do_pop;

   assign full_o  = (count == FULL_CNT);
   assign empty_o = (count == 3'd0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign head_o  = mem[rd_ptr];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
         for (int i = 0; i < 4; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= data_i;
            wr_ptr      <= (wr_ptr == LAST) ? 2'd0 : wr_ptr + 2'd1;
         end
         if (do_pop)
            rd_ptr <= (rd_ptr == LAST) ? 2'd0 : rd_ptr + 2'd1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/obi_sram_arb.sv
// Two-master OBI arbiter in front of one SRAM data port; out-of-window requests are
// granted locally and answered with an error response in grant order.
module obi_sram_arb
   import soc_pkg::*;
#(
   parameter logic [31:0] SRAM_BASE_ADDR  = SRAM_BASE,
   parameter logic [31:0] SRAM_END_ADDR   = SRAM_END,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,

   input  logic        m0_req_i,
   input  logic        m0_we_i,
   input  logic [31:0] m0_addr_i,
   input  logic [3:0]  m0_be_i,
   input  logic [31:0] m0_wdata_i,
   output logic        m0_gnt_o,
   output logic        m0_rvalid_o,
   output logic        m0_err_o,
   output logic [31:0] m0_rdata_o,

   input  logic        m1_req_i,
   input  logic        m1_we_i,
   input  logic [31:0] m1_addr_i,
   input  logic [3:0]  m1_be_i,
   input  logic [31:0] m1_wdata_i,
   output logic        m1_gnt_o,
   output logic        m1_rvalid_o,
   output logic        m1_err_o,
   output logic [31:0] m1_rdata_o,

   output logic        s_req_o,
   output logic        s_we_o,
   output logic [31:0] s_addr_o,
   output logic [3:0]  s_be_o,
   output logic [31:0] s_wdata_o,
   input  logic        s_gnt_i,
   input  logic        s_rvalid_i,
   input  logic [31:0] s_rdata_i,

   output logic        illegal_memory_o
);

   logic        rr_ptr;       // 0: m0 has priority, 1: m1 has priority
   logic        win;          // 0: m0 wins, 1: m1 wins
   logic        arb_ok, win_hit, win_gnt;
   logic        fifo_full, fifo_empty, rsp_fire;
   logic [31:0] rsp_data;
   rsp_tag_t    push_tag, head;

   always_comb begin
      win      = (m0_req_i & m1_req_i) ? rr_ptr : m1_req_i;
      arb_ok   = (m0_req_i | m1_req_i) & ~fifo_full & ~rst_i;
      s_we_o    = win ? m1_we_i    : m0_we_i;
      s_addr_o  = win ? m1_addr_i  : m0_addr_i;
      s_be_o    = win ? m1_be_i    : m0_be_i;
      s_wdata_o = win ? m1_wdata_i : m0_wdata_i;
      win_hit  = in_window(s_addr_o, SRAM_BASE_ADDR, SRAM_END_ADDR);
      s_req_o  = arb_ok & win_hit;
      // A miss never touches the SRAM, so it is granted immediately
      win_gnt  = arb_ok & (win_hit ? s_gnt_i : 1'b1);
      m0_gnt_o = win_gnt & ~win;
      m1_gnt_o = win_gnt &  win;
      illegal_memory_o = arb_ok & ~win_hit;
      push_tag.id  = win;
      push_tag.err = ~win_hit;
   end

   obi_rsp_fifo #(.DEPTH(MAX_OUTSTANDING)) u_rsp_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (win_gnt),
      .data_i  (push_tag),
      .pop_i   (rsp_fire),
      .head_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      // A pending error response yields to any SRAM beat arriving in the same cycle
      rsp_fire    = ~fifo_empty & ~rst_i & (head.err ? ~s_rvalid_i : s_rvalid_i);
      rsp_data    = head.err ? 32'h0 : s_rdata_i;
      m0_rvalid_o = rsp_fire & ~head.id;
      m1_rvalid_o = rsp_fire &  head.id;
      m0_err_o    = m0_rvalid_o & head.err;
      m1_err_o    = m1_rvalid_o & head.err;
      m0_rdata_o  = m0_rvalid_o ? rsp_data : 32'h0;
      m1_rdata_o  = m1_rvalid_o ? rsp_data : 32'h0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)        rr_ptr <= 1'b0;
      else if (win_gnt) rr_ptr <= ~win;
   end

endmodule
